sb1287_adc_controller: RTL and testbench

SB1287_ADC_CONTROLLER -- requirements
Module: sb1287_adc_controller

---
 rtl/sb1287_adc_controller_pkg.sv | 37 +++
 rtl/sb1287_adc_controller_edge_detect.sv | 38 +++
 rtl/sb1287_adc_controller.sv | 197 +++++++++++++++++++
 tb/tb_sb1287_adc_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb1287_adc_controller_pkg.sv
// ---------------------------------------------------------------------------
// sb1287_adc_controller_pkg
// Shared definitions for the SB1287 ADC scan controller: FSM state encoding,
// frame geometry, result width and averaging depth, plus a helper that maps a
// frame bit index onto the channel-address bit carried on din_adc.
// ---------------------------------------------------------------------------
package sb1287_adc_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int FRAME_BITS     = 16;
    localparam int ADDR_BIT_FIRST = 2;
    localparam int DATA_BITS      = 12;
    localparam int AVG_DEPTH      = 4;
    localparam int ACC_BITS       = 14;

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [1:0] AVG_LAST = 2'(AVG_DEPTH - 1);

    // Frame bits ADDR_BIT_FIRST..ADDR_BIT_FIRST+2 carry the channel address
    // MSB first; every other bit of the frame is driven low.
    function automatic logic addr_bit(input logic [3:0] bit_idx, input logic [2:0] ch);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bit_idx == 4'(ADDR_BIT_FIRST + i)) begin
                r = ch[2 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sb1287_adc_controller_edge_detect.sv
// ---------------------------------------------------------------------------
// sb1287_edge_detect
// Two-flop register for the divided ADC clock, which arrives as data in the
// clk_50M domain, and single-cycle rise/fall pulses derived from it.
//   clk_50M : system clock
//   rst_n   : synchronous active-low reset
//   sig     : incoming divided clock
//   level   : second-stage flop (delayed copy of sig)
//   rise    : one-cycle pulse, s1 & ~s2
//   fall    : one-cycle pulse, ~s1 & s2
// ---------------------------------------------------------------------------
module sb1287_edge_detect (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
        end
    end

    assign level = s2;
    assign rise  = s1 & ~s2;
    assign fall  = ~s1 & s2;

endmodule

// File: rtl/sb1287_adc_controller.sv
// ---------------------------------------------------------------------------
// sb1287_adc_controller
// Round-robin scan controller for a serial 12-bit ADC. Each 16-bit frame
// sends the address of one channel and returns the conversion of the channel
// addressed in the previous frame.
//   clk_50M    : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   adc_clk_in : 3.125 MHz divided clock, edge-detected as data
//   enable     : permits new frames to start
//   dout_adc   : ADC serial data out
//   adc_cs_n   : ADC chip select, active low
//   adc_sck    : ADC serial clock
//   din_adc    : ADC serial data in (channel address)
//   ch_data    : latest result
//   ch_id      : channel of ch_data
//   ch_valid   : one-cycle qualifier for ch_data/ch_id
//   scan_done  : pulses with ch_valid of channel NUM_CH-1
// Optional feature macro SB1287_ADC_AVG_EN: average 4 results per channel
// before output.
// ---------------------------------------------------------------------------
module sb1287_adc_controller
    import sb1287_adc_controller_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic                 adc_clk_in,
    input  logic                 enable,
    input  logic                 dout_adc,
    output logic                 adc_cs_n,
    output logic                 adc_sck,
    output logic                 din_adc,
    output logic [DATA_BITS-1:0] ch_data,
    output logic [2:0]           ch_id,
    output logic                 ch_valid,
    output logic                 scan_done
);

    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    state_t                 state;
    logic                   s2;
    logic                   rise;
    logic                   fall;
    logic [3:0]             bit_cnt;
    logic                   gap_fall_seen;
    logic [2:0]             addr_ch;
    logic [2:0]             prev_ch;
    logic [2:0]             next_ch;
    logic                   have_prev;
    logic [FRAME_BITS-1:0]  shift;
    logic [DATA_BITS-1:0]   result;
    logic                   unused_msb;

    sb1287_edge_detect u_edge (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .sig     (adc_clk_in),
        .level   (s2),
        .rise    (rise),
        .fall    (fall)
    );

    assign next_ch = (addr_ch == LAST_CH) ? 3'd0 : addr_ch + 3'd1;

    // The result includes the bit arriving on the final rise so it can be
    // registered on that same edge; the four leading bits are dropped.
    assign result     = {shift[DATA_BITS-2:0], dout_adc};
    assign unused_msb = shift[FRAME_BITS-1];

    // SCK follows the synchronised clock only inside a frame, idles high.
    assign adc_sck = (state == FRAME) ? s2 : 1'b1;

`ifdef SB1287_ADC_AVG_EN
    logic [ACC_BITS-1:0] acc     [NUM_CH];
    logic [1:0]          acc_cnt [NUM_CH];
    logic [ACC_BITS-1:0] sel_sum;
    logic [1:0]          sel_cnt;

    // Running sum including the incoming result for the channel being reported.
    always_comb begin
        sel_sum = '0;
        sel_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (prev_ch == 3'(c)) begin
                sel_sum = acc[c] + {{(ACC_BITS-DATA_BITS){1'b0}}, result};
                sel_cnt = acc_cnt[c];
            end
        end
    end
`endif

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state         <= IDLE;
            adc_cs_n      <= 1'b1;
            din_adc       <= 1'b0;
            ch_data       <= '0;
            ch_id         <= '0;
            ch_valid      <= 1'b0;
            scan_done     <= 1'b0;
            bit_cnt       <= '0;
            gap_fall_seen <= 1'b0;
            addr_ch       <= '0;
            prev_ch       <= '0;
            have_prev     <= 1'b0;
            shift         <= '0;
`ifdef SB1287_ADC_AVG_EN
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c]     <= '0;
                acc_cnt[c] <= '0;
            end
`endif
        end else begin
            ch_valid  <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A fresh scan always begins at channel 0 and has no
                    // earlier address whose result it could return.
                    if (fall && enable) begin
                        state     <= FRAME;
                        adc_cs_n  <= 1'b0;
                        bit_cnt   <= '0;
                        shift     <= '0;
                        addr_ch   <= 3'd0;
                        have_prev <= 1'b0;
                        din_adc   <= addr_bit(4'd0, 3'd0);
                    end
                end
                FRAME: begin
                    if (fall) begin
                        din_adc <= addr_bit(bit_cnt, addr_ch);
                    end
                    if (rise) begin
                        shift <= {shift[FRAME_BITS-2:0], dout_adc};
                        if (bit_cnt == LAST_BIT) begin
                            state         <= GAP;
                            gap_fall_seen <= 1'b0;
                            if (have_prev) begin
`ifdef SB1287_ADC_AVG_EN
                                if (sel_cnt == AVG_LAST) begin
                                    ch_data   <= sel_sum[ACC_BITS-1:2];
                                    ch_id     <= prev_ch;
                                    ch_valid  <= 1'b1;
                                    scan_done <= (prev_ch == LAST_CH);
                                end
                                for (int c = 0; c < NUM_CH; c++) begin
                                    if (prev_ch == 3'(c)) begin
                                        if (sel_cnt == AVG_LAST) begin
                                            acc[c]     <= '0;
                                            acc_cnt[c] <= '0;
                                        end else begin
                                            acc[c]     <= sel_sum;
                                            acc_cnt[c] <= acc_cnt[c] + 2'd1;
                                        end
                                    end
                                end
`else
                                ch_data   <= result;
                                ch_id     <= prev_ch;
                                ch_valid  <= 1'b1;
                                scan_done <= (prev_ch == LAST_CH);
`endif
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                GAP: begin
                    // First fall releases chip select; the second ends the gap.
                    if (fall) begin
                        if (!gap_fall_seen) begin
                            adc_cs_n      <= 1'b1;
                            gap_fall_seen <= 1'b1;
                        end else if (enable) begin
                            state     <= FRAME;
                            adc_cs_n  <= 1'b0;
                            bit_cnt   <= '0;
                            shift     <= '0;
                            prev_ch   <= addr_ch;
                            addr_ch   <= next_ch;
                            have_prev <= 1'b1;
                            din_adc   <= addr_bit(4'd0, next_ch);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb1287_adc_controller.sv
// ---------------------------------------------------------------------------
// tb_sb1287_adc_controller
// Self-checking bench for sb1287_adc_controller (NUM_CH=3). An ADC model
// decodes the address on din_adc and returns a per-channel value in the
// following frame; expected results are queued at frame start and compared
// when ch_valid appears. Build with SB1287_ADC_AVG_EN to check averaging.
// ---------------------------------------------------------------------------
module tb_sb1287_adc_controller;

    localparam int NUM_CH = 3;
`ifdef SB1287_ADC_AVG_EN
    localparam int RUN_FRAMES = 14;
`else
    localparam int RUN_FRAMES = 6;
`endif

    typedef struct {
        logic [2:0]  id;
        logic [11:0] data;
        logic        scan;
    } exp_t;

    logic        clk_50M;
    logic        rst_n;
    logic        adc_clk_in;
    logic        enable;
    logic        dout_adc;
    logic        adc_cs_n;
    logic        adc_sck;
    logic        din_adc;
    logic [11:0] ch_data;
    logic [2:0]  ch_id;
    logic        ch_valid;
    logic        scan_done;

    int   total;
    int   bad;
    exp_t sbQ[$];

    // ADC model state
    logic        fresh;
    logic        forceOnes;
    logic        prevCs;
    logic        prevSck;
    logic        prevValid;
    logic        expectOut;
    logic [2:0]  capAddr;
    logic [15:0] word;
    logic [11:0] value;
    int          idx;
    int          rc;
    int          curExp;
    int          prevExp;
    int          framesStarted;
    int          framesDone;
    int          resultCount [NUM_CH];
    int          accSum      [NUM_CH];
    int          accCnt      [NUM_CH];

    sb1287_adc_controller #(.NUM_CH(NUM_CH)) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .adc_clk_in (adc_clk_in),
        .enable     (enable),
        .dout_adc   (dout_adc),
        .adc_cs_n   (adc_cs_n),
        .adc_sck    (adc_sck),
        .din_adc    (din_adc),
        .ch_data    (ch_data),
        .ch_id      (ch_id),
        .ch_valid   (ch_valid),
        .scan_done  (scan_done)
    );

    initial begin
        clk_50M = 1'b0;
        forever #10 clk_50M = ~clk_50M;
    end

    initial begin
        adc_clk_in = 1'b0;
        #3;
        forever #160 adc_clk_in = ~adc_clk_in;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic enVal);
        @(negedge clk_50M);
        rst_n  = rstVal;
        enable = enVal;
    endtask

    function automatic logic [11:0] valueFor(input int ch);
`ifdef SB1287_ADC_AVG_EN
        int base [NUM_CH] = '{100, 1000, 2000};
        return 12'(base[ch] + resultCount[ch]);
`else
        logic [11:0] tbl [NUM_CH] = '{12'h3C1, 12'hA5C, 12'h5A7};
        return tbl[ch];
`endif
    endfunction

    task automatic scoreResult(input int ch, input logic [11:0] v);
`ifdef SB1287_ADC_AVG_EN
        accSum[ch] += int'(v);
        accCnt[ch]++;
        resultCount[ch]++;
        if (accCnt[ch] == 4) begin
            sbQ.push_back('{id: 3'(ch), data: 12'(accSum[ch] >> 2), scan: (ch == NUM_CH - 1)});
            expectOut  = 1'b1;
            accSum[ch] = 0;
            accCnt[ch] = 0;
        end
`else
        sbQ.push_back('{id: 3'(ch), data: v, scan: (ch == NUM_CH - 1)});
        expectOut = 1'b1;
`endif
    endtask

    task automatic clearModel();
        sbQ.delete();
        fresh = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            resultCount[c] = 0;
            accSum[c]      = 0;
            accCnt[c]      = 0;
        end
    endtask

    task automatic waitFrames(input int n);
        int target;
        target = framesDone + n;
        for (int i = 0; i < 400 * n; i++) begin
            @(negedge clk_50M);
            if (framesDone >= target) break;
        end
        checkOutput("frames_wait", framesDone, target);
    endtask

    task automatic waitBit(input int b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_50M);
            if (!adc_cs_n && rc == b) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("bit_wait", hit, 1);
    endtask

    // ADC model: decodes the address, serves data MSB first on SCK falls,
    // and queues the expected result for the channel addressed last frame.
    initial begin : adcModel
        prevCs        = 1'b1;
        prevSck       = 1'b1;
        prevValid     = 1'b0;
        expectOut     = 1'b0;
        capAddr       = '0;
        word          = '0;
        value         = '0;
        idx           = 0;
        rc            = 0;
        curExp        = 0;
        prevExp       = 0;
        framesStarted = 0;
        framesDone    = 0;
        forever begin
            @(negedge clk_50M);
            if (prevCs && !adc_cs_n) begin
                framesStarted++;
                if (fresh) begin
                    curExp    = 0;
                    prevValid = 1'b0;
                    fresh     = 1'b0;
                end else begin
                    prevExp   = curExp;
                    curExp    = (curExp + 1) % NUM_CH;
                    prevValid = 1'b1;
                end
                value     = forceOnes ? 12'hFFF : valueFor(prevExp);
                word      = forceOnes ? 16'hFFFF : {4'h0, value};
                expectOut = 1'b0;
                if (prevValid) scoreResult(prevExp, value);
                idx      = 0;
                rc       = 0;
                capAddr  = '0;
                dout_adc = word[15];
            end else if (!adc_cs_n && prevSck && !adc_sck) begin
                idx++;
                if (idx < 16) dout_adc = word[15 - idx];
            end
            if (!adc_cs_n && !prevSck && adc_sck) begin
                if (rc >= 2 && rc <= 4) capAddr[4 - rc] = din_adc;
                rc++;
                if (rc == 16) checkOutput("valid_timing", ch_valid, expectOut);
            end
            if (!prevCs && adc_cs_n && rc == 16) begin
                checkOutput("frame_addr", capAddr, curExp);
                framesDone++;
            end
            prevCs  = adc_cs_n;
            prevSck = adc_sck;
        end
    end

    // Scoreboard consumer
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_50M);
            if (ch_valid) begin
                checkOutput("valid_has_entry", sbQ.size() > 0, 1);
                if (sbQ.size() > 0) begin
                    e = sbQ.pop_front();
                    checkOutput("ch_id", ch_id, e.id);
                    checkOutput("ch_data", ch_data, e.data);
                    checkOutput("scan_done", scan_done, e.scan);
                end
            end
            if (scan_done) checkOutput("scan_needs_valid", scan_done, ch_valid);
        end
    end

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : sequencer
        int savedStarted;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        dout_adc  = 1'b0;
        forceOnes = 1'b0;
        clearModel();

        // Reset state
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("rst_cs_n", adc_cs_n, 1);
        checkOutput("rst_sck", adc_sck, 1);
        checkOutput("rst_din", din_adc, 0);
        checkOutput("rst_ch_data", ch_data, 0);
        checkOutput("rst_ch_id", ch_id, 0);
        checkOutput("rst_ch_valid", ch_valid, 0);
        checkOutput("rst_scan_done", scan_done, 0);

        // Continuous scan: addresses 0,1,2,0,... results lag one frame
        $display("[TB] continuous scan");
        applyStimulus(1'b1, 1'b1);
        waitFrames(RUN_FRAMES);

        // All-ones data
        $display("[TB] all-ones frames");
        forceOnes = 1'b1;
        waitFrames(3);
        forceOnes = 1'b0;

        // Enable dropped mid-frame: frame completes, then idle
        $display("[TB] enable drop at bit 5");
        waitBit(5);
        applyStimulus(1'b1, 1'b0);
        waitFrames(1);
        savedStarted = framesStarted;
        repeat (100) @(negedge clk_50M);
        checkOutput("idle_cs_n", adc_cs_n, 1);
        checkOutput("idle_sck", adc_sck, 1);
        checkOutput("idle_no_frame", framesStarted, savedStarted);
        checkOutput("idle_queue_drained", sbQ.size(), 0);

        // Reset at bit 7 of a frame
        $display("[TB] reset mid-frame");
        fresh = 1'b1;
        applyStimulus(1'b1, 1'b1);
        waitFrames(1);
        waitBit(7);
        applyStimulus(1'b0, 1'b1);
        clearModel();
        @(negedge clk_50M);
        checkOutput("midrst_cs_n", adc_cs_n, 1);
        checkOutput("midrst_sck", adc_sck, 1);
        checkOutput("midrst_din", din_adc, 0);
        checkOutput("midrst_valid", ch_valid, 0);
        applyStimulus(1'b1, 1'b1);
        waitFrames(2);

        // Wind down
        waitBit(5);
        applyStimulus(1'b1, 1'b0);
        waitFrames(1);
        repeat (50) @(negedge clk_50M);
        checkOutput("final_queue_drained", sbQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
